// File: rtl/tiny_eth_mac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tiny_eth_mac_tx                                           |
// | Purpose  : MII transmit MAC. Turns a valid/ready byte stream into a  |
// |            nibble-wide Ethernet frame with preamble, SFD, zero       |
// |            padding, optional CRC-32 FCS and an enforced IFG.         |
// | Options  : define TINY_ETH_TX_FCS_EN to build the CRC-32 FCS.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tiny_eth_mac_tx #(
  parameter int IFG_NIBBLES     = 24,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] tx_data,
  output logic       tx_en,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
    S_IFG      = 3'd6
  } state_t;

  localparam logic [10:0] c_min_bytes = 11'(MIN_FRAME_BYTES);
  localparam logic [15:0] c_ifg_last  = 16'(IFG_NIBBLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;        // preamble / FCS / IFG cycle counter
  logic [7:0]  byte_q;       // byte currently on the wire (0 while padding)
  logic        last_q;       // byte_q is the final byte (data or pad)
  logic        half_q;       // 0: low nibble shown, 1: high nibble shown
  logic [10:0] byte_cnt_q;   // bytes emitted so far, saturating
  logic [10:0] byte_cnt_d;
  logic        s_ready_q;
  logic [3:0]  tx_data_q;
  logic        tx_en_q;
  logic        tx_underrun_q;

`ifdef TINY_ETH_TX_FCS_EN
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [27:0] fcs_q;        // remaining FCS nibbles, next one in [3:0]

  // Reflected CRC-32 (poly 0xEDB88320) advanced by one byte, LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // A handshake slot feeds the accepted byte; otherwise a pad byte (0x00) starts
  assign crc_d = crc32_byte(crc_q, s_ready_q ? s_data : 8'h00);
`endif

  assign byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

  // Frame sequencer: every output and counter is registered here
  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      half_q        <= 1'b0;
      byte_cnt_q    <= '0;
      s_ready_q     <= 1'b0;
      tx_data_q     <= '0;
      tx_en_q       <= 1'b0;
      tx_underrun_q <= 1'b0;
`ifdef TINY_ETH_TX_FCS_EN
      crc_q         <= '0;
      fcs_q         <= '0;
`endif
    end else begin
      tx_underrun_q <= 1'b0;
      if (s_ready_q) begin
        // Handshake slot (SFD or a high nibble): a missing byte aborts the frame
        if (!s_valid) begin
          state_q       <= S_IFG;
          tx_en_q       <= 1'b0;
          tx_data_q     <= 4'h0;
          s_ready_q     <= 1'b0;
          tx_underrun_q <= 1'b1;
          cnt_q         <= '0;
        end else begin
          state_q    <= S_DATA;
          byte_q     <= s_data;
          last_q     <= s_last;
          half_q     <= 1'b0;
          tx_data_q  <= s_data[3:0];
          s_ready_q  <= 1'b0;
          byte_cnt_q <= byte_cnt_d;
`ifdef TINY_ETH_TX_FCS_EN
          crc_q      <= crc_d;
`endif
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (s_valid) begin
              state_q    <= S_PREAMBLE;
              tx_en_q    <= 1'b1;
              tx_data_q  <= 4'h5;
              cnt_q      <= 16'd1;
              byte_cnt_q <= '0;
`ifdef TINY_ETH_TX_FCS_EN
              crc_q      <= 32'hFFFFFFFF;
`endif
            end
          end
          S_PREAMBLE: begin
            if (cnt_q == 16'd15) begin
              state_q   <= S_SFD;
              tx_data_q <= 4'hD;
              s_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          // Pad bytes reuse the data path as 0x00 bytes flagged as last
          S_DATA, S_PAD: begin
            if (!half_q) begin
              tx_data_q <= byte_q[7:4];
              half_q    <= 1'b1;
              s_ready_q <= !last_q;
            end else if (byte_cnt_q < c_min_bytes) begin
              state_q    <= S_PAD;
              byte_q     <= 8'h00;
              last_q     <= 1'b1;
              half_q     <= 1'b0;
              tx_data_q  <= 4'h0;
              byte_cnt_q <= byte_cnt_d;
`ifdef TINY_ETH_TX_FCS_EN
              crc_q      <= crc_d;
`endif
            end else begin
`ifdef TINY_ETH_TX_FCS_EN
              state_q   <= S_FCS;
              tx_data_q <= ~crc_q[3:0];
              fcs_q     <= ~crc_q[31:4];
              cnt_q     <= 16'd1;
`else
              state_q   <= S_IFG;
              tx_en_q   <= 1'b0;
              tx_data_q <= 4'h0;
              cnt_q     <= '0;
`endif
            end
          end
`ifdef TINY_ETH_TX_FCS_EN
          S_FCS: begin
            if (cnt_q == 16'd8) begin
              state_q   <= S_IFG;
              tx_en_q   <= 1'b0;
              tx_data_q <= 4'h0;
              cnt_q     <= '0;
            end else begin
              tx_data_q <= fcs_q[3:0];
              fcs_q     <= {4'h0, fcs_q[27:4]};
              cnt_q     <= cnt_q + 16'd1;
            end
          end
`endif
          S_IFG: begin
            if (cnt_q == c_ifg_last) begin
              if (s_valid) begin
                state_q    <= S_PREAMBLE;
                tx_en_q    <= 1'b1;
                tx_data_q  <= 4'h5;
                cnt_q      <= 16'd1;
                byte_cnt_q <= '0;
`ifdef TINY_ETH_TX_FCS_EN
                crc_q      <= 32'hFFFFFFFF;
`endif
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_en       = tx_en_q;
  assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny_eth_mac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tiny_eth_mac_tx                                        |
// | Purpose  : Self-checking bench for tiny_eth_mac_tx. A frame-level    |
// |            model turns each stimulus frame into its nibble stream.   |
// | Options  : honours TINY_ETH_TX_FCS_EN like the design.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tiny_eth_mac_tx;

  localparam int IFG  = 24;
  localparam int MINB = 60;
`ifdef TINY_ETH_TX_FCS_EN
  localparam int FCS_NIBS = 8;
`else
  localparam int FCS_NIBS = 0;
`endif

  logic       tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [3:0] tx_data;
  logic       tx_en;
  logic       tx_underrun;

  always #5 tx_clk = ~tx_clk;

  tiny_eth_mac_tx #(
    .IFG_NIBBLES     (IFG),
    .MIN_FRAME_BYTES (MINB)
  ) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_underrun (tx_underrun)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame_buf [0:2199];
  logic [3:0]  nib_q [$];
  int          len_q [$];
  int          frames_done = 0;
  int          last_len = 0;
  int          last_gap = 0;
  int          ur_seen = 0;
  logic [3:0]  last_nib = 4'h0;
  logic [31:0] last_residue = 32'h0;
  bit          flush = 1'b0;
  int          acc_cnt = 0;
  int          iv_bad = 0;
  int          cyc = 0;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial CRC-32 over one byte, data bits taken LSB first
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Expected wire image of frame_buf[0:len-1]; trunc >= 0 stops after that many bytes
  task automatic push_expected(input int len, input int trunc);
    int          nb;
    logic [31:0] crc;
    logic [7:0]  b;
    for (int i = 0; i < 15; i++) nib_q.push_back(4'h5);
    nib_q.push_back(4'hD);
    nb  = (trunc >= 0) ? trunc : ((len > MINB) ? len : MINB);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < nb; i++) begin
      b = (i < len) ? frame_buf[i] : 8'h00;
      nib_q.push_back(b[3:0]);
      nib_q.push_back(b[7:4]);
      crc = crc_step(crc, b);
    end
    if (trunc < 0) begin
      crc = ~crc;
      for (int i = 0; i < FCS_NIBS; i++) nib_q.push_back(crc[4*i +: 4]);
      len_q.push_back(16 + 2*nb + FCS_NIBS);
    end else begin
      len_q.push_back(16 + 2*nb);
    end
  endtask

  // Drive one frame; ur_at drops s_valid at that handshake, rst_at resets before that byte
  task automatic send_frame(input int len, input int ur_at, input int rst_at, input bit keep);
    int t;
    int last_acc;
    push_expected(len, (ur_at >= 0) ? ur_at : -1);
    acc_cnt  = 0;
    iv_bad   = 0;
    last_acc = -1;
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = frame_buf[i];
      s_last  = (i == len - 1);
      if (i == rst_at) begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        nib_q.delete();
        len_q.delete();
        flush   = 1'b1;
        return;
      end
      t = 0;
      while (!s_ready && t < 10000) begin
        @(negedge tx_clk);
        t++;
      end
      if (!s_ready) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: byte %0d not accepted, got no s_ready in %0d cycles", i, t);
        s_valid = 1'b0;
        return;
      end
      if (i == ur_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      if (last_acc >= 0 && (cyc - last_acc) != 2) iv_bad++;
      last_acc = cyc;
      acc_cnt++;
      @(negedge tx_clk);
    end
    if (!keep) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 20000) begin
      @(negedge tx_clk);
      t++;
    end
    check("frame_done_in_time", (frames_done >= n), 1);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) frame_buf[i] = 8'($urandom);
  endtask

  // Compare process: every tx_en-high cycle against the model's nibble stream
  initial begin : monitor
    bit          in_frame = 1'b0;
    int          hi = 0;
    int          low = 1000;
    int          cur_len = 0;
    logic [3:0]  nibs [0:4999];
    logic [3:0]  e;
    logic [31:0] r;
    forever begin
      @(posedge tx_clk);
      #1;
      if (tx_underrun) begin
        ur_seen++;
        check("underrun_with_tx_en_low", tx_en, 0);
      end
      if (tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          hi       = 0;
          last_gap = low;
          if (len_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_start: tx_en rose, got a frame, expected none");
            cur_len = -1;
          end else begin
            cur_len = len_q.pop_front();
          end
        end
        if (nib_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL nibble: got 0x%0h, expected no nibble", tx_data);
        end else begin
          e = nib_q.pop_front();
          check($sformatf("nibble[%0d]", hi), tx_data, e);
        end
        if (hi < 5000) nibs[hi] = tx_data;
        hi++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          last_len = hi;
          low      = 0;
          last_nib = (hi > 0 && hi <= 5000) ? nibs[hi-1] : 4'h0;
          r = 32'hFFFFFFFF;
          for (int k = 16; (k + 1 < hi) && (k + 1 < 5000); k += 2) r = crc_step(r, {nibs[k+1], nibs[k]});
          last_residue = ~r;
          if (flush) flush = 1'b0;
          else       check("frame_length", hi, cur_len);
          frames_done++;
        end
        low++;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] c;
    int          exp_frames;
    int          len;
    bit          back;

    // Pin the model CRC against the standard check value of "123456789"
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, 8'(49 + i));
    check("crc_model_check_value", ~c, 32'hCBF43926);

    // Reset state
    repeat (3) @(negedge tx_clk);
    check("reset_tx_en", tx_en, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_tx_underrun", tx_underrun, 0);
    check("reset_tx_data", tx_data, 0);
    rst = 1'b1;
    @(negedge tx_clk);

    // Minimum frame: single 0xAB byte, padded
    frame_buf[0] = 8'hAB;
    send_frame(1, -1, -1, 1'b0);
    wait_frames(1);
    check("min_frame_tx_en_cycles", last_len, 136 + FCS_NIBS);
`ifdef TINY_ETH_TX_FCS_EN
    check("min_frame_crc_residue", last_residue, 32'h2144DF1C);
`else
    check("min_frame_last_nibble_pad", last_nib, 4'h0);
`endif

    // 64-byte ramp, no padding, one handshake every 2 cycles
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i);
    send_frame(64, -1, -1, 1'b0);
    check("ramp64_handshakes", acc_cnt, 64);
    check("ramp64_handshake_spacing_errors", iv_bad, 0);
    wait_frames(2);
    check("ramp64_tx_en_cycles", last_len, 144 + FCS_NIBS);
`ifdef TINY_ETH_TX_FCS_EN
    check("ramp64_crc_residue", last_residue, 32'h2144DF1C);
`endif

    // Underrun at the 10th handshake, next frame requested immediately
    fill_random(20);
    send_frame(20, 9, -1, 1'b0);
    @(posedge tx_clk);
    #1;
    check("underrun_pulse", tx_underrun, 1);
    check("underrun_tx_en", tx_en, 0);
    @(posedge tx_clk);
    #1;
    check("underrun_pulse_one_cycle", tx_underrun, 0);
    @(negedge tx_clk);
    fill_random(30);
    send_frame(30, -1, -1, 1'b0);
    wait_frames(4);
    check("underrun_gap_at_least_ifg", (last_gap >= IFG), 1);

    // Back-to-back 60-byte frames with s_valid held high
    fill_random(60);
    send_frame(60, -1, -1, 1'b1);
    fill_random(60);
    send_frame(60, -1, -1, 1'b0);
    wait_frames(6);
    check("back_to_back_gap", last_gap, IFG);
    check("back_to_back_len", last_len, 136 + FCS_NIBS);

    // Reset at byte 20 of a 40-byte frame, then a clean frame
    fill_random(40);
    send_frame(40, -1, 20, 1'b0);
    @(posedge tx_clk);
    #1;
    check("midreset_tx_en", tx_en, 0);
    check("midreset_s_ready", s_ready, 0);
    check("midreset_tx_underrun", tx_underrun, 0);
    repeat (2) @(negedge tx_clk);
    rst = 1'b1;
    @(negedge tx_clk);
    fill_random(25);
    send_frame(25, -1, -1, 1'b0);
    wait_frames(8);
    check("after_reset_len", last_len, 136 + FCS_NIBS);

    // Random frames, some back-to-back
    exp_frames = 8;
    for (int n = 0; n < 6; n++) begin
      len  = $urandom_range(1, 120);
      back = (n < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      fill_random(len);
      send_frame(len, -1, -1, back);
      exp_frames++;
      if (!back) repeat ($urandom_range(0, 30)) @(negedge tx_clk);
    end
    wait_frames(exp_frames);

    // Frame longer than the saturating byte counter
    fill_random(2100);
    send_frame(2100, -1, -1, 1'b0);
    wait_frames(exp_frames + 1);
    check("long_frame_tx_en_cycles", last_len, 16 + 4200 + FCS_NIBS);

    repeat (30) @(negedge tx_clk);
    check("model_nibbles_left", nib_q.size(), 0);
    check("underrun_pulse_count", ur_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tiny_eth_mac_tx.md
# tiny_eth_mac_tx

MII-side transmit MAC for tiny_eth; the counterpart of the existing receive path. It accepts frame bytes (destination MAC through payload) on a valid/ready byte stream and emits a complete Ethernet frame as 4-bit MII nibbles. The emitted frame carries preamble, SFD, zero padding up to the minimum length, an optional CRC-32 FCS and an enforced inter-frame gap. It sits between the upstream frame source and the PHY transmit side, clocked by `tx_clk`.

## Interface

**Parameters**
- `IFG_NIBBLES`, default 24 — length of the inter-frame gap in `tx_clk` cycles (24 = 12 bytes).
- `MIN_FRAME_BYTES`, default 60 — minimum frame length before the FCS; shorter frames are zero-padded up to this length.

**Ports**
- `tx_clk` input, 1 — the single clock, one nibble per cycle.
- `rst` input, 1 — synchronous, active-low reset.
- `s_data` input, 8 — frame byte.
- `s_valid` input, 1 — `s_data` and `s_last` are valid.
- `s_last` input, 1 — the current byte is the last byte of the frame.
- `s_ready` output, 1 — the byte is accepted in the cycle where `s_valid && s_ready` is true.
- `tx_data` output, 4 — MII nibble. Low nibble of each byte goes first.
- `tx_en` output, 1 — MII transmit enable.
- `tx_underrun` output, 1 — one-cycle pulse when a frame is aborted because a byte was not available in time.

## Operation

**Outputs are registered. Reset values:** `tx_data`=0, `tx_en`=0, `s_ready`=0, `tx_underrun`=0, FSM=IDLE, counters=0.

**FSM states:** IDLE → PREAMBLE → SFD → DATA → PAD → FCS → IFG → IDLE.

- **IDLE**
  - `tx_en`=0.
  - Go to PREAMBLE when `s_valid`=1.
- **PREAMBLE**
  - 15 cycles of `tx_data`=0x5.
- **SFD**
  - 1 cycle of `tx_data`=0xD.
  - `s_ready`=1 in this cycle, which accepts the first byte.
- **DATA**
  - Each accepted byte is emitted over two cycles: `s_data[3:0]` first, then `s_data[7:4]`.
  - `s_ready`=1 during the cycle that shows the high nibble, unless `s_last` has already been accepted.
  - This gives continuous streaming with one handshake every 2 cycles.
  - Byte counter is 11 bits and saturates at 2047.
  - After the last byte's high nibble: go to PAD if count < `MIN_FRAME_BYTES`, otherwise go to FCS.
- **Underrun**
  - Condition: `s_ready`=1 and `s_valid`=0, in SFD or DATA.
  - Next cycle: `tx_en`=0, `tx_underrun`=1 for that one cycle.
  - FSM goes to IFG. No FCS is sent.
- **PAD**
  - Emit 0x0 nibbles until the byte count reaches `MIN_FRAME_BYTES`.
- **FCS**
  - 8 nibbles of the complemented CRC, low nibble of the low byte first.
  - CRC-32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated over data and pad bytes.
- **IFG**
  - `tx_en`=0 for `IFG_NIBBLES` cycles.
  - On the final IFG cycle, go straight to PREAMBLE if `s_valid`=1, otherwise go to IDLE.

**Boundary cases**
- A frame longer than 2047 bytes is transmitted in full; the counter only saturates.
- `s_last` on the first byte is legal and results in a padded frame.
- Reset asserted mid-frame: outputs and state return to reset values after that edge. The partial frame is simply truncated, with no underrun pulse.

## Timing

- `s_valid` is first sampled high in IDLE at edge E0.
- E1: `tx_en`=1 and the first 0x5 nibble appears.
- E16: 0xD is on `tx_data` and `s_ready`=1 for the first handshake.
- E17: the low nibble of byte 0 appears.
- Frame length in cycles with `tx_en`=1 is 16 + 2·max(N, `MIN_FRAME_BYTES`) + 8·FCS, where FCS = 1 if enabled, else 0.
- The gap between the last and first `tx_en`-high cycles of back-to-back frames is exactly `IFG_NIBBLES` cycles.
- `s_valid` must stay high until accepted. Dropping it while `s_ready`=1 counts as an underrun.

## Configuration

- Macro: `TINY_ETH_TX_FCS_EN`.
- **Defined:** the CRC-32 logic is built and the FCS state emits the 8 FCS nibbles.
- **Undefined:** no CRC logic. DATA/PAD go directly to IFG after the last nibble, and frames are 8 cycles shorter.

## Test plan

- **Minimum frame:** 1 byte 0xAB with `s_last`, FCS enabled.
  - `tx_en` high for 144 cycles.
  - Nibbles: 15×0x5, 0xD, 0xB, 0xA, 118×0x0, then 8 FCS nibbles.
  - zlib CRC-32 over the 60 bytes plus FCS equals 0x2144DF1C.
- **64-byte frame:** bytes 0x00..0x3F sent back-to-back.
  - 64 handshakes, with `s_ready` pulsing every 2nd cycle.
  - No padding; `tx_en` high for 152 cycles.
  - CRC residue equals 0x2144DF1C.
- **Underrun:** `s_valid` deasserted at the 10th handshake.
  - Next cycle: `tx_underrun`=1 for 1 cycle and `tx_en`=0.
  - The next frame starts no earlier than 24 cycles later.
- **Back-to-back frames:** two 60-byte frames with `s_valid` held high throughout.
  - `tx_en` low for exactly 24 cycles between the frames.
  - The second frame is correct.
- **Reset mid-frame:** `rst`=0 at byte 20.
  - After the edge: `tx_en`=0, `s_ready`=0, `tx_underrun`=0.
  - A frame sent after reset is released is bit-exact.
- **FCS compiled out:** 1-byte frame with `TINY_ETH_TX_FCS_EN` undefined.
  - `tx_en` high for 136 cycles.
  - Last nibble is a pad 0x0.
